// File: rtl/pc_fetch_seq.sv
// Program-counter sequencer and instruction-fetch controller with valid/ready hand-off to the decoder.
// Build option: define PC_JMP_ABSOLUTE_EN to make a taken jump load pcb as an absolute target.
module pc_fetch_seq #(
  parameter int unsigned           PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] pcb,
  input  logic                jmp_taken,
  input  logic                halt,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_data,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instr,
  input  logic                instr_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] instr_r;
  logic                req_r;
  logic                valid_r;
  logic                halted_r;
  logic                accept_s;
  logic [PC_WIDTH-1:0] next_pc_s;

  // Next PC on accept: sequential increment or jump (wraps modulo 2^PC_WIDTH).
  always_comb begin
    accept_s  = valid_r & instr_ready;
    next_pc_s = pc_r;
    if (jmp_taken) begin
`ifdef PC_JMP_ABSOLUTE_EN
      next_pc_s = pcb;
`else
      next_pc_s = pc_r + pcb;
`endif
    end else begin
      next_pc_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer FSM; req/valid/halted are registered alongside the state so outputs never see inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_VECTOR;
      instr_r  <= {PC_WIDTH{1'b0}};
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr_r <= imem_data;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (accept_s) begin
            pc_r    <= next_pc_s;
            valid_r <= 1'b0;
            if (halt) begin
              halted_r <= 1'b1;
              state_r  <= ST_HALTED;
            end else begin
              req_r   <= 1'b1;
              state_r <= ST_FETCH;
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
        default: begin
          state_r  <= ST_IDLE;
          req_r    <= 1'b0;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign pc          = pc_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Randomized self-checking bench for pc_fetch_seq against an event-level reference model.
// Honours PC_JMP_ABSOLUTE_EN for the expected jump target.
module tb_pc_fetch_seq;
  logic       clk = 1'b0;
  logic       rst_n, jmp_taken, halt, imem_ack, instr_ready;
  logic [7:0] pcb, imem_data;
  logic       imem_req, instr_valid, halted;
  logic [7:0] imem_addr, instr, pc;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];

  // reference model: what the sequencer should be showing after each edge
  logic       m_idle, m_req, m_valid, m_halted;
  logic [7:0] m_pc, m_instr;

  always #5 clk = ~clk;

  pc_fetch_seq #(.PC_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .pcb(pcb), .jmp_taken(jmp_taken), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready), .pc(pc), .halted(halted)
  );

  function automatic logic [7:0] jump_target(input logic [7:0] cur, input logic [7:0] off);
`ifdef PC_JMP_ABSOLUTE_EN
    return off;
`else
    return 8'(cur + off);
`endif
  endfunction

  // one clock with given inputs; model advances by the spec's event rules
  task automatic step(input logic ack, input logic rdy, input logic jmp, input logic [7:0] off, input logic hlt);
    imem_ack = ack; instr_ready = rdy; jmp_taken = jmp; pcb = off; halt = hlt;
    imem_data = mem[imem_addr];
    if (m_halted) begin
      m_req = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1;
    end else if (m_req && ack) begin
      m_req = 1'b0; m_valid = 1'b1; m_instr = mem[m_pc];
    end else if (m_valid && rdy) begin
      m_pc = jmp ? jump_target(m_pc, off) : 8'(m_pc + 8'd1);
      m_valid = 1'b0;
      if (hlt) m_halted = 1'b1;
      else     m_req = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_edge();
    rst_n = 1'b0; imem_ack = 1'($urandom_range(0, 1));
    instr_ready = 1'($urandom_range(0, 1)); halt = 1'b0; jmp_taken = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_halted = 1'b0;
    m_pc = 8'h00; m_instr = 8'h00;
  endtask

  // reset, leave IDLE, then complete n sequential instructions (ends in FETCH)
  task automatic advance(input int n);
    reset_edge();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset_edge();
    reset_edge();
    checks += 5;
    if (imem_req !== 1'b0)    begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    if (halted !== 1'b0)      begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    if (pc !== 8'h00)         begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
    if (instr !== 8'h00)      begin failures++; $display("FAIL reset_instr got=%h exp=00", instr); end
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checks += 3;
    if (imem_req !== 1'b1)    begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
    if (imem_addr !== 8'h00)  begin failures++; $display("FAIL first_addr got=%h exp=00", imem_addr); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL idle_ack_ignored got=%b exp=0", instr_valid); end
  endtask

  task automatic test_sequential();
    advance(0);
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
      checks += 3;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0)
        begin failures++; $display("FAIL seq_ack_phase i=%0d got=%b%b exp=10", i, instr_valid, imem_req); end
      if (instr !== mem[8'(i)]) begin failures++; $display("FAIL seq_instr i=%0d got=%h exp=%h", i, instr, mem[8'(i)]); end
      if (pc !== 8'(i))         begin failures++; $display("FAIL seq_hold_pc i=%0d got=%h exp=%h", i, pc, 8'(i)); end
      step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
      checks += 2;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1)
        begin failures++; $display("FAIL seq_fetch_phase i=%0d got=%b%b exp=01", i, instr_valid, imem_req); end
      if (imem_addr !== 8'(i + 1))
        begin failures++; $display("FAIL seq_addr i=%0d got=%h exp=%h", i, imem_addr, 8'(i + 1)); end
    end
  endtask

  task automatic test_jump();
    logic [7:0] exp;
`ifdef PC_JMP_ABSOLUTE_EN
    exp = 8'hFC;
`else
    exp = 8'h0C;
`endif
    advance(16);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hFC, 1'b0);
    checks += 2;
    if (imem_req !== 1'b1)  begin failures++; $display("FAIL jump_req got=%b exp=1", imem_req); end
    if (imem_addr !== exp)  begin failures++; $display("FAIL jump_addr got=%h exp=%h", imem_addr, exp); end
    // jump by zero refetches the same address
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    checks += 1;
    if (imem_addr !== m_pc) begin failures++; $display("FAIL jump_zero got=%h exp=%h", imem_addr, m_pc); end
  endtask

  task automatic test_wait_hold();
    logic [7:0] held;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
      checks += 2;
      if (imem_req !== 1'b1)    begin failures++; $display("FAIL wait_req c=%0d got=%b exp=1", i, imem_req); end
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL wait_valid c=%0d got=%b exp=0", i, instr_valid); end
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    held = mem[m_pc];
    for (int i = 0; i < 4; i++) begin
      checks += 3;
      if (instr_valid !== 1'b1) begin failures++; $display("FAIL hold_valid c=%0d got=%b exp=1", i, instr_valid); end
      if (instr !== held)       begin failures++; $display("FAIL hold_instr c=%0d got=%h exp=%h", i, instr, held); end
      if (imem_req !== 1'b0)    begin failures++; $display("FAIL hold_no_fetch c=%0d got=%b exp=0", i, imem_req); end
      step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checks += 2;
    if (imem_req !== 1'b1)  begin failures++; $display("FAIL hold_release_req got=%b exp=1", imem_req); end
    if (imem_addr !== m_pc) begin failures++; $display("FAIL hold_release_addr got=%h exp=%h", imem_addr, m_pc); end
  endtask

  task automatic test_halt();
    advance(32);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h05, 1'b1);
    checks += 1;
`ifdef PC_JMP_ABSOLUTE_EN
    if (pc !== 8'h05) begin failures++; $display("FAIL halt_pc got=%h exp=05", pc); end
`else
    if (pc !== 8'h25) begin failures++; $display("FAIL halt_pc got=%h exp=25", pc); end
`endif
    for (int i = 0; i < 20; i++) begin
      checks += 3;
      if (halted !== 1'b1)      begin failures++; $display("FAIL halt_flag c=%0d got=%b exp=1", i, halted); end
      if (imem_req !== 1'b0)    begin failures++; $display("FAIL halt_req c=%0d got=%b exp=0", i, imem_req); end
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL halt_valid c=%0d got=%b exp=0", i, instr_valid); end
      step(1'(i % 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_mid_fetch();
    advance(51);
    checks += 2;
    if (imem_req !== 1'b1)   begin failures++; $display("FAIL mid_pre_req got=%b exp=1", imem_req); end
    if (imem_addr !== 8'h33) begin failures++; $display("FAIL mid_pre_addr got=%h exp=33", imem_addr); end
    reset_edge();
    checks += 3;
    if (imem_req !== 1'b0)    begin failures++; $display("FAIL mid_rst_req got=%b exp=0", imem_req); end
    if (pc !== 8'h00)         begin failures++; $display("FAIL mid_rst_pc got=%h exp=00", pc); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", instr_valid); end
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checks += 3;
    if (imem_req !== 1'b1)    begin failures++; $display("FAIL mid_late_ack_req got=%b exp=1", imem_req); end
    if (imem_addr !== 8'h00)  begin failures++; $display("FAIL mid_post_addr got=%h exp=00", imem_addr); end
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_late_ack_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_random();
    reset_edge();
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && $urandom_range(0, 9) == 0) reset_edge();
      step(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30),
           8'($urandom), ($urandom_range(0, 99) < 3));
      checks += 4;
      if (imem_req !== m_req)     begin failures++; $display("FAIL rnd_req c=%0d got=%b exp=%b", i, imem_req, m_req); end
      if (instr_valid !== m_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", i, instr_valid, m_valid); end
      if (halted !== m_halted)    begin failures++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", i, halted, m_halted); end
      if (pc !== m_pc)            begin failures++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", i, pc, m_pc); end
      if (m_valid) begin
        checks++;
        if (instr !== m_instr) begin failures++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", i, instr, m_instr); end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    rst_n = 1'b0; jmp_taken = 1'b0; halt = 1'b0; imem_ack = 1'b0;
    instr_ready = 1'b0; pcb = 8'h00; imem_data = 8'h00;
    m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_pc = 8'h00; m_instr = 8'h00;
    test_reset();
    test_sequential();
    test_jump();
    test_wait_hold();
    test_halt();
    test_reset_mid_fetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
